// File: rtl/obstacle_slot_scheduler.sv
// ---------------------------------------------------------------------------
// obstacle_slot_scheduler
//
// Owns the fixed-size obstacle table read by the track renderer and the
// death checker. Free slots are handed out to spawn requests from the
// obstacle generator. On every frame trigger the table is swept one slot per
// cycle: each active obstacle moves toward the player by the latched speed,
// and an obstacle whose position would reach or pass the player is retired.
//
// Ports:
//   clk_in         system clock (65 MHz domain)
//   rst_n_in       synchronous active-low reset, highest priority
//   game_reset     synchronous active-high table clear, aborts a sweep
//   frame_trigger  one-cycle pulse per video frame, starts a sweep from IDLE
//   speed          position decrement per frame, latched at sweep start
//   spawn_req      level request, held until spawn_ack or spawn_reject
//   spawn_type     sprite type for the new obstacle
//   spawn_lane     lane for the new obstacle (0..2)
//   spawn_ack      one-cycle pulse, request accepted and slot written
//   spawn_reject   one-cycle pulse, request refused, table unchanged
//   busy           high while a sweep is in progress
//   active_count   number of active slots (registered)
//   slots_out      flat table, slot i = {type, pos, lane, active}
//
// Build option:
//   OBSTACLE_LANE_GUARD_EN  when defined, a spawn is refused if any active
//                           obstacle in the requested lane is still closer
//                           than MIN_GAP to SPAWN_POS.
// ---------------------------------------------------------------------------
module obstacle_slot_scheduler #(
   parameter int unsigned NUM_SLOTS = 10,
   parameter int unsigned POS_W     = 11,
   parameter int unsigned SPAWN_POS = 1023,
   parameter int unsigned MIN_GAP   = 128
) (
   input  logic                                 clk_in,
   input  logic                                 rst_n_in,
   input  logic                                 game_reset,
   input  logic                                 frame_trigger,
   input  logic [3:0]                           speed,
   input  logic                                 spawn_req,
   input  logic [1:0]                           spawn_type,
   input  logic [1:0]                           spawn_lane,
   output logic                                 spawn_ack,
   output logic                                 spawn_reject,
   output logic                                 busy,
   output logic [$clog2(NUM_SLOTS+1)-1:0]       active_count,
   output logic [NUM_SLOTS*(POS_W+5)-1:0]       slots_out
);

   localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
   localparam int unsigned IDX_W  = $clog2(NUM_SLOTS);
   localparam int unsigned SLOT_W = POS_W + 5;
   localparam int          GUARD_LIM = int'(SPAWN_POS) - int'(MIN_GAP);

`ifdef OBSTACLE_LANE_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [3:0]             speed_q, speed_d;
   logic [1:0]             type_q [NUM_SLOTS];
   logic [1:0]             type_d [NUM_SLOTS];
   logic [POS_W-1:0]       pos_q  [NUM_SLOTS];
   logic [POS_W-1:0]       pos_d  [NUM_SLOTS];
   logic [1:0]             lane_q [NUM_SLOTS];
   logic [1:0]             lane_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]   act_q, act_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ack_q, ack_d;
   logic                   rej_q, rej_d;

   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic                   lane_hit;
   logic                   lane_blocked;
   logic [POS_W-1:0]       spd_ext;

   // Lowest-index inactive slot.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!act_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Same-lane spacing check; only takes effect when the guard is built in.
   always_comb begin
      lane_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (act_q[i] && (lane_q[i] == spawn_lane) && (int'(pos_q[i]) > GUARD_LIM))
            lane_hit = 1'b1;
      end
   end

   assign lane_blocked = GUARD_EN && lane_hit;

   // Next-state, table update and response pulses.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      speed_d = speed_q;
      type_d  = type_q;
      pos_d   = pos_q;
      lane_d  = lane_q;
      act_d   = act_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      rej_d   = 1'b0;
      busy    = (state_q == SWEEP);
      spd_ext = POS_W'(speed_q);

      if (game_reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            type_d[i] = '0;
            pos_d[i]  = '0;
            lane_d[i] = '0;
         end
         act_d   = '0;
         cnt_d   = '0;
         idx_d   = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_trigger) begin
                  speed_d = speed;
                  idx_d   = '0;
                  state_d = SWEEP;
               end else if (spawn_req && !ack_q && !rej_q) begin
                  // The pulse registers block re-evaluating a request that
                  // the requester has not yet had a chance to drop.
                  if (lane_blocked || !free_found) begin
                     rej_d = 1'b1;
                  end else begin
                     type_d[free_idx] = spawn_type;
                     pos_d[free_idx]  = POS_W'(SPAWN_POS);
                     lane_d[free_idx] = spawn_lane;
                     act_d[free_idx]  = 1'b1;
                     cnt_d            = cnt_q + CNT_W'(1);
                     ack_d            = 1'b1;
                  end
               end
            end
            SWEEP: begin
               if (act_q[idx_q]) begin
                  if (pos_q[idx_q] <= spd_ext) begin
                     act_d[idx_q] = 1'b0;
                     pos_d[idx_q] = '0;
                     cnt_d        = cnt_q - CNT_W'(1);
                  end else begin
                     pos_d[idx_q] = pos_q[idx_q] - spd_ext;
                  end
               end
               if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         idx_q   <= '0;
         speed_q <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            type_q[i] <= '0;
            pos_q[i]  <= '0;
            lane_q[i] <= '0;
         end
         act_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         speed_q <= speed_d;
         type_q  <= type_d;
         pos_q   <= pos_d;
         lane_q  <= lane_d;
         act_q   <= act_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rej_q   <= rej_d;
      end
   end

   assign spawn_ack    = ack_q;
   assign spawn_reject = rej_q;
   assign active_count = cnt_q;

   always_comb begin
      slots_out = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++)
         slots_out[i*SLOT_W +: SLOT_W] = {type_q[i], pos_q[i], lane_q[i], act_q[i]};
   end

endmodule

// File: doc/obstacle_slot_scheduler.md
Name: obstacle_slot_scheduler

Overview:
Owns the fixed-size obstacle table that feeds the track renderer and death checker.
- Allocates free slots to spawn requests from the obstacle generator.
- On each frame trigger, sweeps the table one slot per cycle, advancing positions toward the player by the current speed and retiring obstacles that pass the player.
- Publishes the table as a flat packed bus.

Parameters:
NUM_SLOTS, 10, number of obstacle slots (2..15)
POS_W, 11, position field width
SPAWN_POS, 1023, position written into a newly spawned obstacle (must be >= 1)
MIN_GAP, 128, minimum same-lane spacing when the lane guard is enabled

Ports:
clk_in  in  1  system clock (65 MHz domain)
rst_n_in  in  1  synchronous active-low reset
game_reset  in  1  synchronous active-high table clear
frame_trigger  in  1  one-cycle pulse per video frame
speed  in  4  position decrement per frame, unsigned
spawn_req  in  1  spawn request, level, held until spawn_ack or spawn_reject
spawn_type  in  2  obstacle sprite type
spawn_lane  in  2  obstacle lane (0..2 valid)
spawn_ack  out  1  one-cycle pulse: request accepted
spawn_reject  out  1  one-cycle pulse: request refused
busy  out  1  high while a sweep is in progress
active_count  out  $clog2(NUM_SLOTS+1)  number of active slots
slots_out  out  NUM_SLOTS*(POS_W+5)  slot i at bits [(i+1)*(POS_W+5)-1 : i*(POS_W+5)], packed as {type[1:0], pos[POS_W-1:0], lane[1:0], active}

Behaviour:
Reset (rst_n_in=0, sampled at clk_in):
- All slots are zero.
- spawn_ack, spawn_reject, busy and active_count are 0.
- State is IDLE, sweep index is 0.
- rst_n_in has priority over everything else.

game_reset=1 (next priority):
- Clears every slot and active_count in that cycle.
- Aborts any sweep; state goes to IDLE, busy=0.
- Suppresses any ack/reject for that cycle.
- Any spawn request pending at that point is dropped without a response.

States: IDLE, SWEEP.

IDLE:
- frame_trigger=1: latch speed into speed_q, set idx=0, go to SWEEP; busy=1 from the next cycle.
- Otherwise, if spawn_req=1 and spawn_ack=0 and spawn_reject=0, evaluate a spawn:
  - Choose the lowest-index inactive slot.
  - If one exists, it becomes {spawn_type, SPAWN_POS, spawn_lane, 1} at the next edge, spawn_ack=1 for exactly one cycle, and active_count increments.
  - If none exists, spawn_reject=1 for exactly one cycle and the table is unchanged.
- frame_trigger and spawn_req together: the frame wins; the spawn is evaluated in the first IDLE cycle after the sweep completes.

SWEEP (one slot per cycle, idx 0..NUM_SLOTS-1):
- Active slot with pos <= speed_q: active=0, pos=0, active_count decrements.
- Active slot with pos > speed_q: pos = pos - speed_q (no underflow possible).
- Inactive slots are untouched; type and lane are never modified by a sweep.
- After processing idx=NUM_SLOTS-1, go to IDLE; busy=0 on the following cycle.
- Sweep length is exactly NUM_SLOTS cycles.
- frame_trigger during SWEEP is ignored, with no queuing.
- spawn_req during SWEEP is held off with no ack/reject.

Other rules:
- speed=0: the sweep runs, nothing moves, nothing retires.
- A held spawn_req still high two cycles after the ack cycle is treated as a new request. The requester drops req on the cycle ack/reject is seen.
- slots_out and active_count are registered; both reflect the update one cycle after the processing/accept cycle.
- Invariant: active_count always equals the popcount of the active bits.

Optional Feature:
OBSTACLE_LANE_GUARD_EN
- Defined: a spawn is rejected (spawn_reject pulse, no slot written) if any active slot in spawn_lane has pos > SPAWN_POS - MIN_GAP. This check takes precedence over free-slot allocation.
- Undefined: lane spacing is not checked and only the free-slot rule applies.

Test Plan:
1. Reset then idle: rst_n_in=0 for 2 cycles -> slots_out=0, active_count=0, busy=0. Spawn type=2 lane=1 -> spawn_ack next cycle; slot0={2,1023,1,1}; active_count=1.
2. Sweep timing: slot0 pos=1023, speed=5, pulse frame_trigger -> busy high for exactly 10 cycles; slot0 pos=1018 afterwards. A second frame_trigger mid-sweep changes nothing.
3. Retire boundary: slot pos=5, speed=5 -> retired (active=0, pos=0, count-1). Pos=6, speed=5 -> pos=1, still active.
4. Full table: spawn 10 times -> 10 acks, active_count=10. 11th request -> spawn_reject, table unchanged. Retire slot3, then request -> slot3 reused.
5. Priority: frame_trigger and spawn_req in the same IDLE cycle -> sweep first, ack 1 cycle after busy falls. game_reset at sweep idx 4 -> all slots 0, busy=0 next cycle, no ack.
6. Lane guard (macro defined): lane 0 obstacle at pos=1000, MIN_GAP=128, spawn lane 0 -> reject. Spawn lane 1 -> ack. Without the macro, the lane 0 spawn -> ack.
